// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory to SRAM-bus bridge.
//   - FSM state encodings (IDLE / REQ / WAIT / DONE)
//   - bus transfer size codes (byte / half / word)
//   - kseg0/kseg1 segment detect used by the optional address map
package dmem_bridge_pkg;

  // FSM states, kept as plain constants for legacy tool compatibility.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Bus data_size encodings.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Latched request presented on the bus while a transaction is open.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
  } req_ctl_t;

  // True for the unmapped kernel segments 100 (kseg0) and 101 (kseg1).
  function automatic logic is_kseg(input logic [2:0] seg);
    return (seg == 3'b100) || (seg == 3'b101);
  endfunction

endpackage

// File: rtl/dmem_size_enc.sv
// Combinational decode of the memory-stage byte enables into bus request fields.
// Ports:
//   mem_wen_i  - byte write enables, 0000 = read
//   mem_addr_i - byte address from the memory stage
//   wr_o       - 1 for a write
//   size_o     - bus transfer size (byte / half / word)
//   addr_o     - address with low bits set to the lowest enabled lane (00 for reads)
module dmem_size_enc #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [3:0]        mem_wen_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic              wr_o,
  output logic [1:0]        size_o,
  output logic [ADDR_W-1:0] addr_o
);
  import dmem_bridge_pkg::*;

  logic [1:0] offset;

  // Incoming low address bits are replaced by the lane offset derived from the enables.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  always_comb begin
    size_o = SIZE_WORD;
    unique case (mem_wen_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SIZE_BYTE;
      4'b0011, 4'b1100:                   size_o = SIZE_HALF;
      default:                            size_o = SIZE_WORD;
    endcase
  end

  // Lowest enabled lane; irregular patterns still go out as a word from that lane.
  always_comb begin
    offset = 2'd0;
    if (mem_wen_i[0]) begin
      offset = 2'd0;
    end else if (mem_wen_i[1]) begin
      offset = 2'd1;
    end else if (mem_wen_i[2]) begin
      offset = 2'd2;
    end else if (mem_wen_i[3]) begin
      offset = 2'd3;
    end
  end

  assign wr_o   = |mem_wen_i;
  assign addr_o = {mem_addr_i[ADDR_W-1:2], offset};

endmodule

// File: rtl/dmem_sram_bridge.sv
// Bridge from the single-cycle memory-stage data port to an SRAM-like split-transaction bus
// (req / addr_ok / data_ok). Stalls the memory stage until the access completes and holds the
// read data while the pipeline is frozen by other sources, so an access is never reissued.
// Optional: define DMEM_ADDR_MAP_EN to fold kseg0/kseg1 addresses (bits [31:29] = 100/101)
// down to physical by clearing bits [31:29].
// Ports:
//   clk_i, rst_i                      - clock, synchronous active-high reset
//   mem_en_i, mem_wen_i, mem_addr_i,
//   mem_wdata_i                       - memory-stage request
//   other_stall_i                     - pipeline frozen by another source
//   mem_rdata_o, mem_stall_o          - read data and stall back to the memory stage
//   data_req_o, data_wr_o, data_size_o,
//   data_addr_o, data_wdata_o         - bus request
//   data_addr_ok_i, data_data_ok_i,
//   data_rdata_i                      - bus responses
// DATA_W must be 32.
module dmem_sram_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_en_i,
  input  logic [3:0]        mem_wen_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              other_stall_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stall_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);
  import dmem_bridge_pkg::*;

  logic [1:0]        state_q, state_d;
  req_ctl_t          ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              enc_wr;
  logic [1:0]        enc_size;
  logic [ADDR_W-1:0] enc_addr;
  logic [ADDR_W-1:0] map_addr;

  dmem_size_enc #(
    .ADDR_W(ADDR_W)
  ) u_size_enc (
    .mem_wen_i (mem_wen_i),
    .mem_addr_i(mem_addr_i),
    .wr_o      (enc_wr),
    .size_o    (enc_size),
    .addr_o    (enc_addr)
  );

`ifdef DMEM_ADDR_MAP_EN
  always_comb begin
    map_addr = enc_addr;
    if (is_kseg(enc_addr[ADDR_W-1 -: 3])) begin
      map_addr[ADDR_W-1 -: 3] = 3'b000;
    end
  end
`else
  assign map_addr = enc_addr;
`endif

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (mem_en_i) begin
          ctl_d.wr   = enc_wr;
          ctl_d.size = enc_size;
          addr_d     = map_addr;
          wdata_d    = mem_wdata_i;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (data_addr_ok_i) begin
          // data_ok only counts here when it rides on the accepting cycle.
          if (data_data_ok_i) begin
            if (!ctl_q.wr) begin
              rdata_d = data_rdata_i;
            end
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_data_ok_i) begin
          if (!ctl_q.wr) begin
            rdata_d = data_rdata_i;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        // A still-high mem_en here is the same instruction; only leave once the pipe advances.
        if (!other_stall_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_req_o   = (state_q == StReq);
  assign data_wr_o    = ctl_q.wr;
  assign data_size_o  = ctl_q.size;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign mem_rdata_o  = rdata_q;

  // Stall rises combinationally in the detect cycle so the pipe never advances past the access.
  assign mem_stall_o = !rst_i && (((state_q == StIdle) && mem_en_i) ||
                                  (state_q == StReq) || (state_q == StWait));

endmodule

// File: tb/tb_dmem_sram_bridge.sv
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        other_stall;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  dmem_sram_bridge #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_en_i      (mem_en),
    .mem_wen_i     (mem_wen),
    .mem_addr_i    (mem_addr),
    .mem_wdata_i   (mem_wdata),
    .other_stall_i (other_stall),
    .mem_rdata_o   (mem_rdata),
    .mem_stall_o   (mem_stall),
    .data_req_o    (data_req),
    .data_wr_o     (data_wr),
    .data_size_o   (data_size),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .data_addr_ok_i(data_addr_ok),
    .data_data_ok_i(data_data_ok),
    .data_rdata_i  (data_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: word-aligned address plus the lowest enabled lane, then optional segment fold.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] wen);
    int low;
    logic [31:0] r;
    low = 0;
    for (int i = 3; i >= 0; i--) begin
      if (wen[i]) low = i;
    end
    r = (a & 32'hFFFF_FFFC) + 32'(low);
`ifdef DMEM_ADDR_MAP_EN
    if ((r >> 29) == 32'd4 || (r >> 29) == 32'd5) r = r & 32'h1FFF_FFFF;
`endif
    return r;
  endfunction

  function automatic logic [1:0] model_size(input logic [3:0] wen);
    if (wen == 4'b0000) return 2'd2;
    if ($countones(wen) == 1) return 2'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // One access: addr_ok after da REQ cycles; data_ok dd cycles later (0 = same cycle);
  // then os cycles of other_stall in DONE. Entered and left at posedge+1 in IDLE.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd,
                         input logic [31:0] rd, input int da, input int dd, input int os);
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic        e_wr;
    int          stalls;
    e_addr = model_addr(addr, wen);
    e_size = model_size(wen);
    e_wr   = (wen != 4'b0000);
    stalls = 0;

    mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wd;
    other_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    check("detect_req", 32'(data_req), 32'd0);
    if (mem_stall) stalls++;
    tick();

    for (int c = 0; c <= da; c++) begin
      data_addr_ok = (c == da);
      data_data_ok = (c == da) && (dd == 0);
      data_rdata   = rd;
      @(negedge clk);
      check("req", 32'(data_req), 32'd1);
      check("wr", 32'(data_wr), 32'(e_wr));
      check("size", 32'(data_size), 32'(e_size));
      check("addr", data_addr, e_addr);
      check("wdata", data_wdata, wd);
      if (mem_stall) stalls++;
      tick();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;

    for (int c = 1; c <= dd; c++) begin
      data_data_ok = (c == dd);
      data_rdata   = rd;
      @(negedge clk);
      check("wait_req", 32'(data_req), 32'd0);
      if (mem_stall) stalls++;
      tick();
    end
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    if (!e_wr) exp_rdata = rd;
    check("stall_cycles", 32'(stalls), 32'(2 + da + dd));

    for (int c = 0; c <= os; c++) begin
      other_stall = (c < os);
      @(negedge clk);
      check("done_stall", 32'(mem_stall), 32'd0);
      check("done_req", 32'(data_req), 32'd0);
      check("rdata", mem_rdata, exp_rdata);
      tick();
    end
    other_stall = 1'b0;
    mem_en = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(mem_stall), 32'd0);
    check("idle_req", 32'(data_req), 32'd0);
    tick();
  endtask

  initial begin
    logic [3:0] wen;
    rst = 1'b1; mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    other_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    tick();
    tick();
    @(negedge clk);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_wr", 32'(data_wr), 32'd0);
    check("rst_size", 32'(data_size), 32'd0);
    check("rst_addr", data_addr, 32'h0);
    check("rst_wdata", data_wdata, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    tick();
    rst = 1'b0; mem_en = 1'b0;
    tick();

    // Directed cases.
    run_txn(32'h0000_0104, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    run_txn(32'h0000_0200, 4'b0100, 32'h00AB_0000, 32'h1234_5678, 0, 1, 0);
    run_txn(32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0, 5, 2, 0);
    run_txn(32'h0000_0400, 4'b0000, 32'h0, 32'h5A5A_A5A5, 0, 1, 4);
    run_txn(32'h0000_0500, 4'b0000, 32'h0, 32'h0BAD_F00D, 0, 0, 1);
    run_txn(32'hA000_1000, 4'b0000, 32'h0, 32'h7777_1111, 1, 1, 0);
    run_txn(32'h8000_2003, 4'b1100, 32'hBEEF_0000, 32'h0, 0, 1, 0);
    run_txn(32'h0000_0600, 4'b0110, 32'h00FF_FF00, 32'h0, 0, 1, 0);

    // Reset while waiting for data_ok.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_0700;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    @(negedge clk);
    check("wait_stall", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    tick();
    exp_rdata = 32'h0;
    @(negedge clk);
    check("midrst_req", 32'(data_req), 32'd0);
    check("midrst_stall", 32'(mem_stall), 32'd0);
    check("midrst_rdata", mem_rdata, 32'h0);
    rst = 1'b0; mem_en = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_idle_req", 32'(data_req), 32'd0);
    tick();

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      wen = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      run_txn($urandom, wen, $urandom, $urandom, $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
